pwl_act_interp: RTL and testbench
=================================

// Module: pwl_act_interp
// PURPOSE
//  Pipelined piecewise-linear activation unit for NN4H neuron datapaths.
//  Splits a signed input into segment index and fraction, looks up segment
//  start and end values in a run-time loadable LUT, and linearly interpolates.
//  Sits between the accumulator and the next layer, with valid/ready handshake.
// PARAMETERS
//  ADDR_W  4  LUT index bits; LUT depth = 2**ADDR_W.
//  FRAC_W  4  fraction bits (low bits of in_data).
//  IN_W    8  input width; must equal ADDR_W+FRAC_W.
//  DATA_W  8  signed LUT entry and output width.
// PORTS
//  clk        in   1       clock, rising edge.
//  rst        in   1       asynchronous reset, active-low.
//  in_valid   in   1       input sample valid.
//  in_ready   out  1       unit accepts a sample this cycle.
//  in_data    in   IN_W    signed input; [IN_W-1:FRAC_W] = idx, [FRAC_W-1:0] = frac.
//  out_valid  out  1       output sample valid.
//  out_ready  in   1       downstream accepts the output.
//  out_data   out  DATA_W  signed interpolated result.
//  cfg_we     in   1       LUT write strobe.
//  cfg_addr   in   ADDR_W  LUT write address.
//  cfg_data   in   DATA_W  signed LUT write data.
// BEHAVIOUR
//  - Reset (rst=0): all stage valids and out_valid=0, out_data=0, all LUT entries=0.
//  - Pipeline: S1 lookup, registers base, nxt and frac. S2 registers
//    diff*frac. S3 registers base+shifted product. Latency is 3 clk from
//    accept to out_valid.
//  - Global stall: en = !out_valid | out_ready. in_ready = en. All stages
//    advance only when en=1. A bubble is a stage valid of 0 and moves
//    like data. Throughput is 1 sample/clk when out_ready stays high.
//  - Accept: in_valid & in_ready. Output transfer: out_valid & out_ready.
//    out_data stays stable while out_valid=1 and out_ready=0.
//  - Index rule: idx is read as unsigned address. base = lut[idx].
//    nxt = lut[idx+1 mod depth], which wraps from the all-ones index to 0.
//    Exception: idx = 2**(ADDR_W-1)-1 (largest positive segment) uses
//    nxt = base, which holds the output flat at the top.
//  - Arithmetic: diff = nxt-base, signed DATA_W+1 bits. frac is unsigned,
//    zero-extended. prod = diff*frac, signed DATA_W+FRAC_W+2 bits.
//    y = base + (prod >>> FRAC_W), arithmetic shift (floor).
//    y always lies in [min(base,nxt), max(base,nxt)], so truncation to
//    DATA_W is exact and no saturation is needed.
//  - LUT write: on cfg_we, lut[cfg_addr] <= cfg_data at the clk edge.
//    The write is visible to S1 lookups from the next cycle on, whether or
//    not the pipeline is stalled. Samples already past S1 are unaffected.
//  - cfg_we during a stall is accepted. Back-to-back writes to one address:
//    the last write wins.
//  - Reset mid-operation flushes all in-flight samples and clears the LUT.
//    No output is produced for samples accepted before reset.
// CONFIGURATION
//  PWL_ACT_ROUND_EN defined: y = base + ((prod + 2**(FRAC_W-1)) >>> FRAC_W),
//    i.e. round-half-up. Latency and handshake are unchanged.
//  PWL_ACT_ROUND_EN undefined: floor (truncating) shift as above.
// TESTING  (defaults; LUT loaded 0,12,15,15,15,15,15,15,-15 x7,-12 at addr 0..15)
//  1. Load LUT, drive in_data=8'h18 with out_ready=1 -> out_data=13 three clk
//     after accept. With PWL_ACT_ROUND_EN -> 14.
//  2. in_data=8'h7F (idx 7, top clamp) -> 15. in_data=8'h88 -> -15.
//     in_data=8'hF8 (wrap to lut[0]) -> -6.
//  3. Stream 8 samples back-to-back with out_ready=1 -> 8 outputs on
//     consecutive cycles, in order, in_ready stays 1.
//  4. Hold out_ready=0 for 5 clk with a full pipeline -> in_ready=0, out_data
//     stable. Release -> no loss and no duplication.
//  5. Write lut[2]=-4 while a sample with idx 1 sits in S2; then send
//     8'h18 -> first result 13, second 12+((-16*8)>>>4) = 4.
//  6. Assert rst low with 3 samples in flight -> out_valid=0 at once and
//     stays 0. Re-send 8'h18 with no LUT load -> out_data=0.

Source files
------------

// File: rtl/pwl_act_interp.sv
`default_nettype none
// ============================================================================
// Module   : pwl_act_interp
// Purpose  : Pipelined piecewise-linear activation unit. The signed input is
//            split into a segment index (upper bits) and a fraction (lower
//            bits). The segment start/end values come from a run-time
//            loadable LUT, and the result is linearly interpolated between them.
//            Three register stages sit behind one global valid/ready stall.
// Ports    : clk               rising-edge clock
//            rst               asynchronous reset, active-low
//            in_valid/in_ready input handshake, in_data = {idx, frac}
//            out_valid/out_ready output handshake, out_data = interpolated y
//            cfg_we/cfg_addr/cfg_data  LUT write port (works during stalls)
// Options  : PWL_ACT_ROUND_EN  round-half-up instead of floor on the final
//                              shift; latency and handshake are unchanged
// Revision : 1.0  initial release
// ============================================================================
module pwl_act_interp #(
  parameter int ADDR_W = 4,
  parameter int FRAC_W = 4,
  parameter int IN_W   = 8,   // must equal ADDR_W + FRAC_W
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data
);

  localparam int DEPTH  = 2**ADDR_W;
  localparam int PROD_W = DATA_W + FRAC_W + 2;

  // Largest positive segment: its right neighbour would be the most negative
  // segment, so interpolation is suppressed and the output stays flat.
  localparam logic [ADDR_W-1:0] c_top_idx = {1'b0, {(ADDR_W-1){1'b1}}};

  logic [DATA_W-1:0] r_lut [DEPTH];

  logic                     w_en;
  logic [ADDR_W-1:0]        w_idx;
  logic [ADDR_W-1:0]        w_idx_nxt;
  logic [FRAC_W-1:0]        w_frac;
  logic [DATA_W-1:0]        w_base;
  logic [DATA_W-1:0]        w_nxt;
  logic [DATA_W:0]          w_diff;
  logic [PROD_W-1:0]        w_prod;
  logic signed [PROD_W-1:0] w_adj;
  logic signed [PROD_W-1:0] w_shift;
  logic [PROD_W-1:0]        w_y;
  logic                     w_unused_y;

  logic                     r_s1_valid;
  logic [DATA_W-1:0]        r_s1_base;
  logic [DATA_W-1:0]        r_s1_nxt;
  logic [FRAC_W-1:0]        r_s1_frac;
  logic                     r_s2_valid;
  logic [DATA_W-1:0]        r_s2_base;
  logic signed [PROD_W-1:0] r_s2_prod;

  // One stall signal for the whole pipe: everything moves when the output
  // slot is empty or being drained this cycle.
  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;

  // ---------------- S1: LUT lookup ----------------
  assign w_idx     = in_data[IN_W-1:FRAC_W];
  assign w_frac    = in_data[FRAC_W-1:0];
  assign w_idx_nxt = w_idx + ADDR_W'(1);   // wraps all-ones back to 0
  assign w_base    = r_lut[w_idx];
  assign w_nxt     = (w_idx == c_top_idx) ? w_base : r_lut[w_idx_nxt];

  // LUT writes are independent of the stall; a write at an edge is seen by
  // lookups from the following cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_lut[i] <= '0;
      end
    end else if (cfg_we) begin
      r_lut[cfg_addr] <= cfg_data;
    end
  end

  // ---------------- S2: slope times fraction ----------------
  assign w_diff = {r_s1_nxt[DATA_W-1], r_s1_nxt} - {r_s1_base[DATA_W-1], r_s1_base};
  // Both operands extended to the product width, so the low PROD_W bits of
  // the unsigned multiply are the correct two's-complement product.
  assign w_prod = {{(PROD_W-DATA_W-1){w_diff[DATA_W]}}, w_diff}
                * {{(PROD_W-FRAC_W){1'b0}}, r_s1_frac};

  // ---------------- S3: base plus scaled product ----------------
`ifdef PWL_ACT_ROUND_EN
  localparam logic signed [PROD_W-1:0] c_half = PROD_W'(2**(FRAC_W-1));
  assign w_adj = r_s2_prod + c_half;
`else
  assign w_adj = r_s2_prod;
`endif
  assign w_shift = w_adj >>> FRAC_W;
  assign w_y     = {{(PROD_W-DATA_W){r_s2_base[DATA_W-1]}}, r_s2_base} + w_shift;
  // The result always lies between base and nxt, so the upper bits are pure
  // sign extension and can be dropped.
  assign w_unused_y = ^w_y[PROD_W-1:DATA_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_base  <= '0;
      r_s1_nxt   <= '0;
      r_s1_frac  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_base  <= '0;
      r_s2_prod  <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else if (w_en) begin
      r_s1_valid <= in_valid;
      r_s1_base  <= w_base;
      r_s1_nxt   <= w_nxt;
      r_s1_frac  <= w_frac;
      r_s2_valid <= r_s1_valid;
      r_s2_base  <= r_s1_base;
      r_s2_prod  <= w_prod;
      out_valid  <= r_s2_valid;
      // Bubbles leave the last result in place.
      if (r_s2_valid) begin
        out_data <= w_y[DATA_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwl_act_interp.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwl_act_interp
// Purpose  : Self-checking bench for pwl_act_interp. A stimulus process drives
//            directed scenarios and a random phase; a monitor process records
//            every accepted sample's expected result (from an arithmetic
//            reference model) in a queue and pops/compares it whenever an
//            output transfer occurs.
// Options  : PWL_ACT_ROUND_EN  selects the round-half-up reference model
// Revision : 1.0  initial release
// ============================================================================
module tb_pwl_act_interp;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       cfg_we;
  logic [3:0] cfg_addr;
  logic [7:0] cfg_data;

  pwl_act_interp dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data)
  );

  always #5 clk = ~clk;

`ifdef PWL_ACT_ROUND_EN
  localparam int EXP_18 = 14;
`else
  localparam int EXP_18 = 13;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int mlut [16];
  int sb [$];
  int got [$];
  int got_cyc [$];
  bit stall_prev = 0;
  int stall_data = 0;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: segment endpoints, linear slope, floor (or half-up) division.
  function automatic int model(input logic [7:0] d);
    int  idx, frac, base, nxt, prod;
    real q;
    idx  = int'(d[7:4]);
    frac = int'(d[3:0]);
    base = mlut[idx];
    nxt  = (idx == 7) ? base : mlut[(idx + 1) % 16];
    prod = (nxt - base) * frac;
`ifdef PWL_ACT_ROUND_EN
    q = $floor(real'(prod + 8) / 16.0);
`else
    q = $floor(real'(prod) / 16.0);
`endif
    return base + int'(q);
  endfunction

  // Monitor / scoreboard: everything observed at the falling edge reflects
  // what the next rising edge will act on.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        sb.delete();
        for (int i = 0; i < 16; i++) mlut[i] = 0;
        stall_prev = 0;
      end else begin
        if (stall_prev)
          check(out_valid && (int'($signed(out_data)) == stall_data), "hold_stable",
                int'($signed(out_data)), stall_data);
        check(in_ready == (!out_valid || out_ready), "in_ready", int'(in_ready),
              int'(!out_valid || out_ready));
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check(0, "unexpected_output", int'($signed(out_data)), 0);
          end else begin
            int e;
            e = sb.pop_front();
            check(int'($signed(out_data)) == e, "out_data", int'($signed(out_data)), e);
          end
          got.push_back(int'($signed(out_data)));
          got_cyc.push_back(cyc);
        end
        stall_prev = out_valid && !out_ready;
        stall_data = int'($signed(out_data));
        if (in_valid && in_ready) sb.push_back(model(in_data));
        if (cfg_we) mlut[cfg_addr] = int'($signed(cfg_data));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    int k;
    bit acc;
    in_valid = 1'b1;
    in_data  = d;
    k = 0;
    do begin
      acc = in_ready;
      tick();
      k++;
    end while (!acc && k < 100);
    check(acc, "send_accept", int'(acc), 1);
  endtask

  task automatic write_lut(input int a, input int d);
    cfg_we   = 1'b1;
    cfg_addr = 4'(a);
    cfg_data = 8'(d);
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic wait_got(input int n);
    int k;
    k = 0;
    while (got.size() < n && k < 60) begin
      tick();
      k++;
    end
    check(got.size() >= n, "output_count", got.size(), n);
  endtask

  task automatic expect_got(input int i, input int e, input string name);
    if (got.size() > i) check(got[i] == e, name, got[i], e);
  endtask

  int table_init [16] = '{0, 12, 15, 15, 15, 15, 15, 15,
                          -15, -15, -15, -15, -15, -15, -15, -12};

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    repeat (3) tick();
    check(out_valid == 1'b0, "reset_out_valid", int'(out_valid), 0);
    check(out_data == 8'd0, "reset_out_data", int'(out_data), 0);
    check(in_ready == 1'b1, "reset_in_ready", int'(in_ready), 1);
    rst = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) write_lut(i, table_init[i]);

    // Basic interpolation
    got.delete();
    send(8'h18); in_valid = 1'b0;
    wait_got(1);
    expect_got(0, EXP_18, "t1_0x18");

    // Top clamp, negative plateau, wrap from index 15 to index 0
    got.delete();
    send(8'h7F); send(8'h88); send(8'hF8); in_valid = 1'b0;
    wait_got(3);
    expect_got(0, 15, "t2_0x7F");
    expect_got(1, -15, "t2_0x88");
    expect_got(2, -6, "t2_0xF8");

    // Back-to-back stream: eight outputs on consecutive cycles
    got.delete(); got_cyc.delete();
    for (int i = 0; i < 8; i++) send(8'($urandom));
    in_valid = 1'b0;
    wait_got(8);
    if (got_cyc.size() >= 8)
      check(got_cyc[7] - got_cyc[0] == 7, "t3_consecutive", got_cyc[7] - got_cyc[0], 7);

    // Full pipeline held by out_ready=0
    got.delete();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_data = 8'($urandom);
      tick();
    end
    check(in_ready == 1'b0, "t4_in_ready_low", int'(in_ready), 0);
    check(out_valid == 1'b1, "t4_out_valid_held", int'(out_valid), 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_got(3);
    repeat (5) tick();
    check(got.size() == 3, "t4_no_dup", got.size(), 3);

    // LUT write while an earlier sample is past S1
    got.delete();
    send(8'h18); in_valid = 1'b0;
    tick();
    write_lut(2, -4);
    send(8'h18); in_valid = 1'b0;
    wait_got(2);
    expect_got(0, EXP_18, "t5_before_write");
    expect_got(1, 4, "t5_after_write");

    // Reset with samples in flight
    send(8'h18); send(8'h7F); send(8'h88);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check(out_valid == 1'b0, "t6_flush_now", int'(out_valid), 0);
    repeat (2) begin
      tick();
      check(out_valid == 1'b0, "t6_in_reset", int'(out_valid), 0);
    end
    rst = 1'b1;
    got.delete();
    repeat (4) tick();
    check(got.size() == 0, "t6_no_stale_output", got.size(), 0);
    send(8'h18); in_valid = 1'b0;
    wait_got(1);
    expect_got(0, 0, "t6_cleared_lut");

    // Random traffic with random backpressure and live LUT writes
    for (int i = 0; i < 16; i++) write_lut(i, int'($signed(8'($urandom))));
    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cfg_we    = ($urandom_range(0, 7) == 0);
      cfg_addr  = 4'($urandom);
      cfg_data  = 8'($urandom);
      tick();
    end
    in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    repeat (10) tick();
    check(sb.size() == 0, "drain_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
